// File: rtl/burst_clk_ctrl_if.sv
// Command/status bundle for burst_clk_ctrl: burst request inputs and gated-clock status outputs.
// The master side issues start/abort and burst settings; the slave side is the controller.
interface burst_clk_ctrl_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [DIV_W-1:0] half_period;
  logic [CNT_W-1:0] burst_len;
  logic             gclk_out;
  logic             tick;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] tick_cnt;

  modport master (
    output start, abort, half_period, burst_len,
    input  gclk_out, tick, busy, done, aborted, tick_cnt
  );

  modport slave (
    input  start, abort, half_period, burst_len,
    output gclk_out, tick, busy, done, aborted, tick_cnt
  );
endinterface

// File: rtl/burst_clk_ctrl.sv
// Gated slow-clock burst generator: emits N periods of a 2*H-cycle clock on start, then stops.
// Abort terminates an active burst immediately; every output is registered.
module burst_clk_ctrl #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  burst_clk_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] ph_q, ph_d;
  logic [DIV_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gclk_q, gclk_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             phase_end;
  logic             start_ok;

  assign phase_end = (ph_q == (h_q - DIV_W'(1)));
  assign start_ok  = bus.start && !bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      h_q       <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      gclk_q    <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      h_q       <= h_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      gclk_q    <= gclk_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Outputs are computed one cycle ahead so they line up with the state being entered.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    h_d       = h_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    gclk_d    = gclk_q;
    tick_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          if ((bus.half_period != '0) && (bus.burst_len != '0)) begin
            h_d     = bus.half_period;
            n_d     = bus.burst_len;
            cnt_d   = CNT_W'(1);
            ph_d    = '0;
            state_d = HIGH;
            gclk_d  = 1'b1;
            tick_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            cnt_d  = '0;
            done_d = 1'b1;
          end
        end
      end

      HIGH: begin
        if (bus.abort) begin
          state_d   = IDLE;
          ph_d      = '0;
          gclk_d    = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (phase_end) begin
          state_d = LOW;
          ph_d    = '0;
          gclk_d  = 1'b0;
        end else begin
          ph_d = ph_q + DIV_W'(1);
        end
      end

      LOW: begin
        // Abort is checked first so it suppresses a completion falling in the same cycle.
        if (bus.abort) begin
          state_d   = IDLE;
          ph_d      = '0;
          gclk_d    = 1'b0;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
        end else if (phase_end) begin
          ph_d = '0;
          if (cnt_q == n_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
            gclk_d  = 1'b1;
            tick_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else begin
          ph_d = ph_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        ph_d    = '0;
        gclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.gclk_out = gclk_q;
  assign bus.tick     = tick_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
  assign bus.tick_cnt = cnt_q;

  a_done_abort_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(done_q && aborted_q));

  a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= n_q);

  a_busy_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy_q == (state_q != IDLE));

endmodule
